// File: rtl/cache_replace_pkg.sv
// Shared types and LFSR constants for the random-replacement victim controller.
// Tap masks are indexed by LFSR width; bit n set means state bit n feeds back.
package cache_replace_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'h02;

  localparam logic [7:0] TAP_W3 = 8'h05;
  localparam logic [7:0] TAP_W4 = 8'h09;
  localparam logic [7:0] TAP_W5 = 8'h1B;
  localparam logic [7:0] TAP_W6 = 8'h36;
  localparam logic [7:0] TAP_W7 = 8'h69;
  localparam logic [7:0] TAP_W8 = 8'hA6;

  function automatic logic [7:0] lfsr_taps(input int w);
    case (w)
      3:       lfsr_taps = TAP_W3;
      4:       lfsr_taps = TAP_W4;
      5:       lfsr_taps = TAP_W5;
      6:       lfsr_taps = TAP_W6;
      7:       lfsr_taps = TAP_W7;
      default: lfsr_taps = TAP_W8;
    endcase
  endfunction

endpackage

// File: rtl/replace_lfsr.sv
// Fibonacci LFSR that shifts right; feedback enters at the MSB.
// Advances only when enabled, so the sequence tracks committed fills.
module replace_lfsr
  import cache_replace_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_state
);

  localparam logic [7:0]   TAPS8 = lfsr_taps(W);
  localparam logic [W-1:0] TAPS  = TAPS8[W-1:0];
  localparam logic [W-1:0] SEED  = LFSR_SEED[W-1:0];

  logic [W-1:0] r_state;
  logic         w_fb;

  assign w_fb = ^(r_state & TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= {w_fb, r_state[W-1:1]};
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/cache_replace_ctrl.sv
// Victim-way selection for a random-replacement set-associative cache.
// Invalid unlocked ways win; otherwise an LFSR-based rotating scan skips locks.
module cache_replace_ctrl
  import cache_replace_pkg::*;
#(
  parameter  int NUMWAYS   = 4,
  localparam int LOGWAYS   = $clog2(NUMWAYS),
  localparam int LFSRWIDTH = (LOGWAYS + 2 > 3) ? LOGWAYS + 2 : 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ReqValid,
  output logic               ReqReady,
  input  logic [NUMWAYS-1:0] ValidWays,
  input  logic [NUMWAYS-1:0] LockedWays,
  output logic               VictimValid,
  output logic [NUMWAYS-1:0] VictimWay,
  output logic               NoVictim,
  input  logic               FillDone,
  input  logic               FlushStage,
  output logic               Busy
);

  state_e               r_state;
  state_e               w_next;
  logic [NUMWAYS-1:0]   r_valid;
  logic [NUMWAYS-1:0]   r_locked;
  logic [NUMWAYS-1:0]   r_victim;
  logic                 r_novictim;
  logic [LFSRWIDTH-1:0] w_lfsr;
  logic [NUMWAYS:0]     w_pick;
  logic                 w_accept;
  logic                 w_adv;
  logic                 w_unused_lfsr;

  // Result is {no_victim, one_hot_way}.
  function automatic logic [NUMWAYS:0] pick_victim(
    input logic [NUMWAYS-1:0] vld,
    input logic [NUMWAYS-1:0] lck,
    input logic [LOGWAYS-1:0] base
  );
    logic [NUMWAYS-1:0] free;
    logic [LOGWAYS-1:0] idx;
    logic               found;
    pick_victim = '0;
    free        = ~vld & ~lck;
    found       = 1'b0;
    for (int i = 0; i < NUMWAYS; i++) begin
      if (!found && free[i]) begin
        pick_victim[i] = 1'b1;
        found          = 1'b1;
      end
    end
    for (int i = 0; i < NUMWAYS; i++) begin
      idx = base + LOGWAYS'(i);
      if (!found && !lck[idx]) begin
        pick_victim[idx] = 1'b1;
        found            = 1'b1;
      end
    end
    if (!found) begin
      pick_victim[NUMWAYS] = 1'b1;
    end
  endfunction

  replace_lfsr #(
    .W(LFSRWIDTH)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_en   (w_adv),
    .o_state(w_lfsr)
  );

  assign w_pick        = pick_victim(r_valid, r_locked, w_lfsr[LOGWAYS-1:0]);
  assign w_unused_lfsr = ^w_lfsr[LFSRWIDTH-1:LOGWAYS];

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_adv    = 1'b0;
    ReqReady = 1'b0;
    unique case (r_state)
      IDLE: begin
        ReqReady = !FlushStage;
        if (ReqValid && !FlushStage) begin
          w_accept = 1'b1;
          w_next   = SELECT;
        end
      end
      SELECT: begin
        w_next = FlushStage ? IDLE : RESP;
      end
      RESP: begin
        if (FlushStage || r_novictim) begin
          w_next = IDLE;
        end else if (FillDone) begin
          w_next = IDLE;
          w_adv  = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_locked   <= '0;
      r_victim   <= '0;
      r_novictim <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_valid  <= ValidWays;
        r_locked <= LockedWays;
      end
      if (r_state == SELECT) begin
        {r_novictim, r_victim} <= w_pick;
      end
    end
  end

  assign Busy        = (r_state != IDLE);
  assign VictimValid = (r_state == RESP);
  assign VictimWay   = VictimValid ? r_victim : '0;
  assign NoVictim    = VictimValid & r_novictim;

endmodule

// File: tb/tb_cache_replace_ctrl.sv
// Directed bench for cache_replace_ctrl (4 ways, 4-bit LFSR) with a
// transaction-level reference model checked every cycle.
module tb_cache_replace_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       ReqValid = 1'b0;
  logic       ReqReady;
  logic [3:0] ValidWays = '0;
  logic [3:0] LockedWays = '0;
  logic       VictimValid;
  logic [3:0] VictimWay;
  logic       NoVictim;
  logic       FillDone = 1'b0;
  logic       FlushStage = 1'b0;
  logic       Busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cache_replace_ctrl #(.NUMWAYS(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ValidWays  (ValidWays),
    .LockedWays (LockedWays),
    .VictimValid(VictimValid),
    .VictimWay  (VictimWay),
    .NoVictim   (NoVictim),
    .FillDone   (FillDone),
    .FlushStage (FlushStage),
    .Busy       (Busy)
  );

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: m_age = -1 idle, 0 choosing, 1 victim presented.
  int         m_age;
  logic [3:0] m_lfsr, m_v, m_l, m_way;
  logic       m_nov;

  function automatic logic [4:0] model_pick(input logic [3:0] v,
                                            input logic [3:0] l,
                                            input logic [3:0] lf);
    logic [1:0] b;
    int base;
    b = lf[1:0];
    base = int'(b);
    for (int i = 0; i < 4; i++)
      if (!v[i] && !l[i]) return {1'b0, 4'(1 << i)};
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (base + k) % 4;
      if (!l[j]) return {1'b0, 4'(1 << j)};
    end
    return 5'b10000;
  endfunction

  function automatic logic [3:0] model_next(input logic [3:0] x);
    return {x[3] ^ x[0], x[3:1]};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_age  = -1;
      m_lfsr = 4'b0010;
      m_way  = '0;
      m_nov  = 1'b0;
    end else begin
      if (m_age == -1) begin
        if (ReqValid && !FlushStage) begin
          m_v   = ValidWays;
          m_l   = LockedWays;
          m_age = 0;
        end
      end else if (m_age == 0) begin
        if (FlushStage) m_age = -1;
        else begin
          {m_nov, m_way} = model_pick(m_v, m_l, m_lfsr);
          m_age = 1;
        end
      end else begin
        if (FlushStage || m_nov) m_age = -1;
        else if (FillDone) begin
          m_lfsr = model_next(m_lfsr);
          m_age  = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      chk("ReqReady", {7'd0, ReqReady},
          {7'd0, (m_age == -1) && !FlushStage});
      chk("Busy", {7'd0, Busy}, {7'd0, m_age != -1});
      chk("VictimValid", {7'd0, VictimValid}, {7'd0, m_age == 1});
      chk("VictimWay", {4'd0, VictimWay},
          {4'd0, (m_age == 1) ? m_way : 4'd0});
      chk("NoVictim", {7'd0, NoVictim},
          {7'd0, (m_age == 1) && m_nov});
      chk("lfsr", {4'd0, dut.u_lfsr.o_state}, {4'd0, m_lfsr});
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n    = 1'b0;
    ReqValid   = 1'b0;
    FillDone   = 1'b0;
    FlushStage = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Returns at negedge+2 of the cycle where the victim is presented.
  task automatic issue(input logic [3:0] v, input logic [3:0] l);
    int n;
    n = 0;
    @(negedge clk);
    while (Busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got busy want idle");
    end
    ReqValid   = 1'b1;
    ValidWays  = v;
    LockedWays = l;
    @(negedge clk);
    ReqValid = 1'b0;
    #2;
    chk("select_busy", {7'd0, Busy}, 8'd1);
    chk("select_vv", {7'd0, VictimValid}, 8'd0);
    @(negedge clk);
    #2;
    chk("resp_vv", {7'd0, VictimValid}, 8'd1);
  endtask

  task automatic fill();
    FillDone = 1'b1;
    @(negedge clk);
    FillDone = 1'b0;
    #2;
  endtask

  task automatic flush();
    FlushStage = 1'b1;
    @(negedge clk);
    FlushStage = 1'b0;
    #2;
  endtask

  logic [3:0] exp_way[4];
  logic [3:0] exp_lf[4];

  initial begin
    exp_way = '{4'b0100, 4'b0010, 4'b0001, 4'b0001};
    exp_lf  = '{4'b0001, 4'b1000, 4'b1100, 4'b1110};
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #2;
    chk("rst_ready", {7'd0, ReqReady}, 8'd1);
    chk("rst_busy", {7'd0, Busy}, 8'd0);
    chk("rst_lfsr", {4'd0, dut.u_lfsr.o_state}, 8'h02);

    // Invalid-way rule, then the fill still advances the LFSR.
    issue(4'b1011, 4'b0000);
    chk("inv_way", {4'd0, VictimWay}, 8'h04);
    fill();
    chk("inv_lfsr", {4'd0, dut.u_lfsr.o_state}, 8'h01);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(4'b1111, 4'b0000);
      chk("rand_way", {4'd0, VictimWay}, {4'd0, exp_way[i]});
      fill();
      chk("rand_lfsr", {4'd0, dut.u_lfsr.o_state}, {4'd0, exp_lf[i]});
    end

    // Lock-skipping scan with wraparound.
    do_reset();
    issue(4'b1111, 4'b0100);
    chk("wrap3", {4'd0, VictimWay}, 8'h08);
    flush();
    issue(4'b1111, 4'b1100);
    chk("wrap0", {4'd0, VictimWay}, 8'h01);
    flush();

    // All locked: single-cycle response, no advance.
    issue(4'b1111, 4'b1111);
    chk("nov_flag", {7'd0, NoVictim}, 8'd1);
    chk("nov_way", {4'd0, VictimWay}, 8'h00);
    @(negedge clk);
    #2;
    chk("nov_vv_drop", {7'd0, VictimValid}, 8'd0);
    chk("nov_lfsr", {4'd0, dut.u_lfsr.o_state}, 8'h02);

    // Flush beats a simultaneous FillDone.
    issue(4'b1111, 4'b0000);
    chk("fl_way", {4'd0, VictimWay}, 8'h04);
    FillDone = 1'b1;
    flush();
    FillDone = 1'b0;
    chk("fl_vv", {7'd0, VictimValid}, 8'd0);
    chk("fl_lfsr", {4'd0, dut.u_lfsr.o_state}, 8'h02);
    issue(4'b1111, 4'b0000);
    chk("fl_again", {4'd0, VictimWay}, 8'h04);
    fill();

    // FillDone while idle is ignored.
    FillDone = 1'b1;
    @(negedge clk);
    FillDone = 1'b0;
    #2;
    chk("idle_fill", {4'd0, dut.u_lfsr.o_state}, 8'h01);

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    FlushStage = 1'b1;
    ReqValid   = 1'b1;
    ValidWays  = 4'b1111;
    LockedWays = 4'b0000;
    #2;
    chk("idle_fl_ready", {7'd0, ReqReady}, 8'd0);
    @(negedge clk);
    #2;
    chk("idle_fl_busy", {7'd0, Busy}, 8'd0);
    FlushStage = 1'b0;
    @(negedge clk);
    ReqValid = 1'b0;
    #2;
    chk("idle_fl_acc", {7'd0, Busy}, 8'd1);

    // Flush during SELECT.
    FlushStage = 1'b1;
    @(negedge clk);
    FlushStage = 1'b0;
    #2;
    chk("sel_fl_busy", {7'd0, Busy}, 8'd0);

    // Asynchronous reset in the middle of RESP.
    issue(4'b1111, 4'b0000);
    chk("ar_way", {4'd0, VictimWay}, 8'h02);
    #1 reset_n = 1'b0;
    #1;
    chk("ar_vv", {7'd0, VictimValid}, 8'd0);
    chk("ar_way0", {4'd0, VictimWay}, 8'h00);
    chk("ar_ready", {7'd0, ReqReady}, 8'd1);
    chk("ar_busy", {7'd0, Busy}, 8'd0);
    chk("ar_lfsr", {4'd0, dut.u_lfsr.o_state}, 8'h02);
    @(negedge clk);
    reset_n = 1'b1;
    issue(4'b0111, 4'b0000);
    chk("post_ar_way", {4'd0, VictimWay}, 8'h08);
    fill();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
